// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Load-use / memory-latency hazard controller for the RV32I pipeline.
// Keeps an in-order scoreboard of destination registers of loads that are
// still waiting for their data-memory response. It raises an ID stall when
// an ID source depends on a pending load, an EX hold when the scoreboard is
// full, and a multi-cycle IF/ID flush after a taken branch.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush cycle counters).

module hazard_scoreboard_unit #(
  parameter int NB_OPERAND      = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [NB_OPERAND-1:0]                  i_id_rs1,
  input  logic [NB_OPERAND-1:0]                  i_id_rs2,
  input  logic                                   i_id_use_rs1,
  input  logic                                   i_id_use_rs2,
  input  logic                                   i_ex_valid,
  input  logic                                   i_ex_is_load,
  input  logic [NB_OPERAND-1:0]                  i_ex_rd,
  input  logic                                   i_mem_rsp_valid,
  input  logic                                   i_branch_taken,
  output logic                                   o_load_hazard,
  output logic                                   o_mem_stall,
  output logic                                   o_flush,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
  output logic                                   o_underflow,
  output logic [31:0]                            o_stall_cycles,
  output logic [31:0]                            o_flush_cycles
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  // Pointers advance modulo the scoreboard depth, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] ent_vld_q, ent_vld_d;
  logic [NB_OPERAND-1:0] ent_rd_q [MAX_OUTSTANDING];
  logic [NB_OPERAND-1:0] ent_rd_d [MAX_OUTSTANDING];
  logic [FCNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                  underflow_q, underflow_d;

  logic ex_load;
  logic full;
  logic push;
  logic pop;
  logic match_rs1;
  logic match_rs2;

  assign ex_load     = i_ex_valid & i_ex_is_load;
  assign full        = (count_q == FULL_CNT);
  assign pop         = i_mem_rsp_valid & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full scoreboard only holds EX without a response.
  assign o_mem_stall = ex_load & full & ~pop;
  assign push        = ex_load & ~o_mem_stall;

  // Source-operand dependency check against the EX load and pending scoreboard entries.
  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
    if (ex_load && (i_id_rs1 == i_ex_rd)) match_rs1 = 1'b1;
    if (ex_load && (i_id_rs2 == i_ex_rd)) match_rs2 = 1'b1;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      // The head entry being popped has its data forwarded from the response.
      if (ent_vld_q[i] && !(pop && (rd_ptr_q == PTR_W'(i)))) begin
        if (ent_rd_q[i] == i_id_rs1) match_rs1 = 1'b1;
        if (ent_rd_q[i] == i_id_rs2) match_rs2 = 1'b1;
      end
    end
    match_rs1 = match_rs1 & i_id_use_rs1 & (i_id_rs1 != '0);
    match_rs2 = match_rs2 & i_id_use_rs2 & (i_id_rs2 != '0);
  end

  assign o_flush       = i_branch_taken | (flush_cnt_q != '0);
  assign o_load_hazard = (match_rs1 | match_rs2) & ~o_flush;
  assign o_outstanding = count_q;
  assign o_underflow   = underflow_q;

  // Scoreboard FIFO next state: pop frees the head, push appends the EX load.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ent_vld_d = ent_vld_q;
    ent_rd_d  = ent_rd_q;
    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      ent_vld_d[wr_ptr_q] = 1'b1;
      ent_rd_d[wr_ptr_q]  = i_ex_rd;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Flush stretch counter and sticky underflow flag next state.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (i_branch_taken)           flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != '0)   flush_cnt_d = flush_cnt_q - 1'b1;
    underflow_d = underflow_q | (i_mem_rsp_valid & (count_q == '0));
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ent_vld_q   <= '0;
      flush_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ent_vld_q   <= ent_vld_d;
      flush_cnt_q <= flush_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry register-address storage; qualified by the valid bits, so no reset.
  always_ff @(posedge i_clock) begin
    ent_rd_q <= ent_rd_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  // Saturating performance counters for stall and flush cycles.
  always_comb begin
    stall_cycles_d = sat_inc(stall_cycles_q, o_load_hazard | o_mem_stall);
    flush_cycles_d = sat_inc(flush_cycles_q, o_flush);
  end

  // Performance counter registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_cycles = flush_cycles_q;
`else
  assign o_stall_cycles = '0;
  assign o_flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_hazard_scoreboard_unit;

  localparam int NB   = 5;
  localparam int MAXO = 4;
  localparam int FC   = 3;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] rs1, rs2, ex_rd;
  logic          use1, use2, ex_valid, ex_is_load, rsp, branch;
  logic          load_hazard, mem_stall, flush, underflow;
  logic [CW-1:0] outstanding;
  logic [31:0]   stall_cycles, flush_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NB_OPERAND(NB), .MAX_OUTSTANDING(MAXO), .FLUSH_CYCLES(FC)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
    .i_mem_rsp_valid(rsp), .i_branch_taken(branch),
    .o_load_hazard(load_hazard), .o_mem_stall(mem_stall), .o_flush(flush),
    .o_outstanding(outstanding), .o_underflow(underflow),
    .o_stall_cycles(stall_cycles), .o_flush_cycles(flush_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending load destinations in issue order.
  int          pend_q[$];
  int          flush_rem;
  bit          m_underflow;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    flush_rem   = 0;
    m_underflow = 0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic idle();
    rst_n = 1'b1; rs1 = '0; rs2 = '0; use1 = 0; use2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = '0; rsp = 0; branch = 0;
  endtask

  task automatic ex_load(input int rd);
    ex_valid = 1; ex_is_load = 1; ex_rd = NB'(rd);
  endtask

  function automatic bit depends(input logic [NB-1:0] rs, input bit use_s, input bit pop);
    if (!use_s || rs == 0) return 0;
    if (ex_valid && ex_is_load && rs == ex_rd) return 1;
    for (int k = (pop ? 1 : 0); k < pend_q.size(); k++)
      if (pend_q[k] == int'(rs)) return 1;
    return 0;
  endfunction

  // Check one cycle against the model, then advance the model across the clock edge.
  task automatic step(input string tag);
    bit pop, ms, push, fl, hz;
    #1;
    pop  = rsp && pend_q.size() != 0;
    ms   = ex_valid && ex_is_load && (pend_q.size() == MAXO) && !pop;
    push = ex_valid && ex_is_load && !ms;
    fl   = branch || flush_rem != 0;
    hz   = (depends(rs1, use1, pop) || depends(rs2, use2, pop)) && !fl;
    chk({tag, "_hazard"},    load_hazard, hz);
    chk({tag, "_memstall"},  mem_stall, ms);
    chk({tag, "_flush"},     flush, fl);
    chk({tag, "_outst"},     outstanding, pend_q.size());
    chk({tag, "_underflow"}, underflow, m_underflow);
    chk({tag, "_stallcnt"},  stall_cycles, m_stall_cnt);
    chk({tag, "_flushcnt"},  flush_cycles, m_flush_cnt);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rsp && pend_q.size() == 0) m_underflow = 1;
      if (pop) void'(pend_q.pop_front());
      if (push) pend_q.push_back(int'(ex_rd));
      flush_rem = branch ? FC - 1 : (flush_rem > 0 ? flush_rem - 1 : 0);
`ifdef HAZARD_PERF_CNT_EN
      if ((hz || ms) && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("reset_idle");

    // Load-use on x5, then response forwards the data.
    ex_load(5); rs1 = 5; use1 = 1;
    #1 chk("lu_hazard_set", load_hazard, 1);
    step("lu_ex");
    idle(); rs1 = 5; use1 = 1; rsp = 1;
    #1 chk("lu_hazard_rsp", load_hazard, 0);
    step("lu_rsp");
    idle();
    #1 chk("lu_outst_zero", outstanding, 0);
    step("lu_idle");

    // Load to x0 never creates a dependency but is still tracked.
    ex_load(0); rs1 = 0; use1 = 1; step("x0_ex");
    idle(); rs1 = 0; use1 = 1;
    #1 chk("x0_outst_one", outstanding, 1);
    step("x0_pend");
    idle(); rsp = 1; step("x0_rsp");
    idle(); step("x0_done");

    // Fill the scoreboard, then a fifth load stalls until a response frees a slot.
    for (int r = 1; r <= 4; r++) begin
      idle(); ex_load(r); step("fill");
    end
    idle(); ex_load(6);
    #1 chk("full_stall", mem_stall, 1);
    step("full_hold");
    rsp = 1;
    #1 chk("full_stall_rsp", mem_stall, 0);
    step("full_pushpop");
    idle();
    #1 chk("full_outst", outstanding, 4);
    for (int r = 0; r < 4; r++) begin
      idle(); rsp = 1; rs1 = 6; use1 = 1; step("drain");
    end

    // Three-cycle flush masks a real dependency on x7.
    idle(); ex_load(7); step("fl_load");
    idle(); rs1 = 7; use1 = 1; branch = 1; step("fl_br");
    branch = 0;
    for (int c = 0; c < 3; c++) step("fl_hold");
    idle(); rsp = 1; step("fl_rsp");

    // Response on empty scoreboard is sticky; reset clears everything mid-operation.
    idle(); rsp = 1; step("uf_rsp");
    idle();
    #1 chk("uf_sticky", underflow, 1);
    ex_load(8); step("uf_l1");
    idle(); ex_load(9); branch = 1; step("uf_l2");
    idle(); rst_n = 1'b0; ex_load(10); step("mid_reset");
    idle();
    #1 chk("rst_outst", outstanding, 0);
    chk("rst_underflow", underflow, 0);
    step("post_reset");

    // Two stall cycles followed by a three-cycle flush.
    idle(); ex_load(5); rs1 = 5; use1 = 1; step("perf_s1");
    idle(); rs1 = 5; use1 = 1; step("perf_s2");
    idle(); rsp = 1; step("perf_rsp");
    idle(); branch = 1; step("perf_br");
    idle(); step("perf_f2");
    step("perf_f3");
    step("perf_end");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_total", stall_cycles, 2);
    chk("perf_flush_total", flush_cycles, 3);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      rs1        = NB'($urandom_range(0, 7));
      rs2        = NB'($urandom_range(0, 7));
      use1       = $urandom_range(0, 3) != 0;
      use2       = $urandom_range(0, 1) != 0;
      ex_valid   = $urandom_range(0, 3) != 0;
      ex_is_load = $urandom_range(0, 1) != 0;
      ex_rd      = NB'($urandom_range(0, 7));
      rsp        = $urandom_range(0, 9) < 4;
      branch     = $urandom_range(0, 11) == 0;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
